// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types for the peripheral bus arbiter: decode targets, FSM states, address pages.
// Pure declarations: no latency and no backpressure.
package periph_bus_pkg;

  typedef enum logic [1:0] {TGT_NONE, TGT_SEG, TGT_GPIO, TGT_CNT} tgt_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  localparam logic [3:0] PAGE_SEG = 4'he;
  localparam logic [3:0] PAGE_IO  = 4'hf;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Master request/response port and device-side strobe bundle of the peripheral bus.
// Signal bundles only: no latency; a master holds req until it sees its ready pulse.
interface periph_mst_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

interface periph_dev_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] per_wdata;
  logic              seg_we;
  logic              seg_re;
  logic              gpio_we;
  logic              cnt_we;
  logic [DATA_W-1:0] seg_rdata;
  logic [DATA_W-1:0] gpio_rdata;
  logic [DATA_W-1:0] cnt_rdata;

  modport master (output per_wdata, seg_we, seg_re, gpio_we, cnt_we,
                  input seg_rdata, gpio_rdata, cnt_rdata);
  modport slave  (input per_wdata, seg_we, seg_re, gpio_we, cnt_we,
                  output seg_rdata, gpio_rdata, cnt_rdata);
endinterface

// File: rtl/periph_bus_arbiter_decode.sv
// Combinational address-to-device decode on the top nibble and bit 2 of the address.
// Zero latency, no backpressure.
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  output tgt_e              o_tgt
);

  logic w_unused;
  assign w_unused = ^{i_addr[ADDR_W-5:3], i_addr[1:0]};

  always_comb begin
    o_tgt = TGT_NONE;
    if (i_addr[ADDR_W-1 -: 4] == PAGE_SEG) begin
      o_tgt = TGT_SEG;
    end else if (i_addr[ADDR_W-1 -: 4] == PAGE_IO) begin
      o_tgt = i_addr[2] ? TGT_CNT : TGT_GPIO;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin two-master arbiter issuing single-cycle device strobes; req->strobe 1 cycle, ->ready 2 cycles.
// One access per 3 cycles; the losing master simply keeps req high and is served next.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = '0
) (
  input  logic         clk,
  input  logic         rstn,
  periph_mst_if.slave  m0,
  periph_mst_if.slave  m1,
  periph_dev_if.master dev,
  output logic         err,
  output logic         grant
);

  state_e              r_state;
  state_e              w_next;
  logic                r_grant;
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_any;
  logic                w_win;
  tgt_e                w_tgt;

  assign w_any = m0.req | m1.req;
  // On a tie the master that was not served last wins; r_last resets to 1 so m0 wins first.
  assign w_win = (m0.req & m1.req) ? ~r_last : m1.req;

  periph_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .i_addr (r_addr),
    .o_tgt  (w_tgt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_we    <= w_win ? m1.we    : m0.we;
            r_addr  <= w_win ? m1.addr  : m0.addr;
            r_wdata <= w_win ? m1.wdata : m0.wdata;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_rdata <= '0;
          end else begin
            case (w_tgt)
              TGT_SEG:  r_rdata <= dev.seg_rdata;
              TGT_GPIO: r_rdata <= dev.gpio_rdata;
              TGT_CNT:  r_rdata <= dev.cnt_rdata;
              default:  r_rdata <= UNMAPPED_DATA;
            endcase
          end
        end
        ST_RESP: r_last <= r_grant;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    dev.seg_we  = 1'b0;
    dev.seg_re  = 1'b0;
    dev.gpio_we = 1'b0;
    dev.cnt_we  = 1'b0;
    m0.ready    = 1'b0;
    m1.ready    = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        dev.seg_we  = r_we  && (w_tgt == TGT_SEG);
        dev.seg_re  = !r_we && (w_tgt == TGT_SEG);
        dev.gpio_we = r_we  && (w_tgt == TGT_GPIO);
        dev.cnt_we  = r_we  && (w_tgt == TGT_CNT);
        w_next      = ST_RESP;
      end
      ST_RESP: begin
        m0.ready = !r_grant;
        m1.ready = r_grant;
        err      = (w_tgt == TGT_NONE);
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign m0.rdata      = m0.ready ? r_rdata : '0;
  assign m1.rdata      = m1.ready ? r_rdata : '0;
  assign grant         = r_grant;
  assign dev.per_wdata = r_wdata;

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
Two-master arbiter and sequencer for the memory-mapped peripheral bus. Requester 0 is the CPU; requester 1 is the debug/host port.
The block serialises accesses, decodes the address and issues single-cycle write/read strobes to three devices: seven-segment store, GPIO/LED, and counter port. It returns registered read data with a ready handshake.
It replaces the combinational address-decode always block in the top level and sits between the CPU/debug masters and the peripheral devices.

Parameters:
DATA_W, 32, data width of the bus and all device read/write data
ADDR_W, 32, address width
UNMAPPED_DATA, 32'h0000_0000, read data returned for an unmapped address

Ports:
clk  in  1  bus clock (CPU clock domain)
rstn  in  1  asynchronous active-low reset
m0_req  in  1  CPU request; held high until m0_ready
m0_we  in  1  CPU write (1) / read (0)
m0_addr  in  ADDR_W  CPU address
m0_wdata  in  DATA_W  CPU write data
m0_ready  out  1  one-cycle completion pulse to CPU
m0_rdata  out  DATA_W  read data, valid while m0_ready=1
m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata  same as m0_*, for the debug master
err  out  1  one-cycle pulse alongside ready for an unmapped address
per_wdata  out  DATA_W  latched write data to devices
seg_we  out  1  seven-segment store write strobe
seg_re  out  1  seven-segment store read strobe
gpio_we  out  1  GPIO/LED write strobe
cnt_we  out  1  counter port write strobe
seg_rdata  in  DATA_W  seven-segment store read data
gpio_rdata  in  DATA_W  GPIO status word
cnt_rdata  in  DATA_W  counter value
grant  out  1  index of the master owning the current transaction

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE. All strobes, ready, err, grant, per_wdata and rdata are 0. Round-robin pointer favours m0.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a winner and latch its we/addr/wdata plus the decoded target. Set grant to the winner. Go to ACCESS.
  - Only one request: that master wins.
  - Both requests: winner is the master not granted last time (round-robin). After reset m0 wins the first tie.
- Address decode (on the latched address):
  - addr[31:28]=4'he -> SEG
  - addr[31:28]=4'hf and addr[2]=1 -> CNT
  - addr[31:28]=4'hf and addr[2]=0 -> GPIO
  - anything else -> NONE
- ACCESS: exactly one cycle. Assert at most one strobe:
  - write: seg_we, gpio_we or cnt_we, per target
  - read of SEG: seg_re
  - GPIO and CNT reads need no strobe
  - NONE: no strobe
  - per_wdata holds the latched data. Go to RESP.
- RESP, one cycle:
  - Pulse the winner's mN_ready.
  - On a read, mN_rdata = target rdata sampled at the start of this cycle (UNMAPPED_DATA for NONE). On a write, mN_rdata = 0.
  - err=1 iff target is NONE.
  - Update the round-robin pointer. Go to IDLE.
- Latency: req seen at edge N -> strobe during cycle N+1 -> ready during cycle N+2. Back-to-back throughput is one access per 3 cycles.
- The loser's request stays pending and is served in the next IDLE. Starvation is impossible: worst-case wait is one transaction.
- Changes to mN_* inputs after latching are ignored until the next IDLE.
- A req dropped before ready (protocol violation) does not abort the transaction; the ready pulse still occurs.
- Reset mid-transaction returns to IDLE immediately. No strobe or ready is emitted after rstn falls.
- Never two strobes in one cycle. Strobes are never asserted outside ACCESS.

Decomposition:
- Shared package (periph_bus_pkg): target enum {TGT_NONE, TGT_SEG, TGT_GPIO, TGT_CNT}, FSM state enum, and page constants PAGE_SEG=4'he and PAGE_IO=4'hf.
- One natural sub-module: periph_addr_decode (combinational address -> target). Reused by the top level and the bench.

Test Plan:
- m0 write 0xE000_0000 data 0x1234_5678 -> seg_we high exactly in cycle 2, per_wdata=0x1234_5678, m0_ready in cycle 3, err=0.
- m1 read 0xF000_0004 with cnt_rdata=0x0000_00AB -> no strobe, m1_rdata=0x0000_00AB with m1_ready, grant=1.
- m0 and m1 both request from reset, then re-request -> order m0, m1, m0, m1; each ready 3 cycles apart.
- m0 read 0x1000_0000 -> m0_rdata=UNMAPPED_DATA, err pulses with m0_ready, no strobes.
- m0 read 0xF000_0000 with gpio_rdata=0x8000_00FF -> no strobes, m0_rdata=0x8000_00FF.
- rstn pulled low during ACCESS of a gpio write -> gpio_we drops asynchronously, no m0_ready. After release, a new request completes normally.
